// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared constants and helpers for the scoreboard hazard unit.
// Holds the latency classes, the register-address width and the countdown-width derivation.
package scoreboard_hazard_unit_pkg;

  localparam int REG_ADDR_W = 4;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;

  // Width that holds the largest countdown, MAX_LAT-1+NOFWD_EXTRA.
  function automatic int cnt_width(input int max_lat, input int nofwd_extra);
    int w;
    w = $clog2(max_lat + nofwd_extra);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_counter.sv
// Per-register result-availability countdown.
// Each cycle it either loads a new count, decrements, or holds at zero.
module scoreboard_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: non-blocking assignment so every counter updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: per-register countdowns drive RAW/WAW stall for variable-latency EXE.
// Optional macro SCOREBOARD_STATS_EN adds saturating stall_cycles / raw_stalls counters.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int REG_FILE_ADDR_LEN = REG_ADDR_W,
  parameter int NUM_REGS          = 16,
  parameter int MAX_LAT           = 8,
  parameter int NOFWD_EXTRA       = 2,
  localparam int CNT_W            = cnt_width(MAX_LAT, NOFWD_EXTRA),
  localparam int LAT_W            = $clog2(MAX_LAT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         forward_EN,
  input  logic                         issue_valid,
  input  logic                         issue_wb_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] issue_dest,
  input  logic [LAT_W-1:0]             issue_lat,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1,
  input  logic                         src1_used,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2,
  input  logic                         src2_used,
  output logic                         stall,
  output logic                         busy,
  output logic [NUM_REGS-1:0]          pending_mask
`ifdef SCOREBOARD_STATS_EN
  , output logic [31:0]                stall_cycles
  , output logic [31:0]                raw_stalls
`endif
);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] src1_cnt, src2_cnt, dest_cnt, newcnt;
  logic [LAT_W-1:0] lat_eff;
  logic             raw, waw, issue_accept;

  assign cnt[0]          = '0;
  assign pending_mask[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (issue_accept && issue_wb_en && (issue_dest == REG_FILE_ADDR_LEN'(r))),
      .load_val (newcnt),
      .cnt      (cnt[r])
    );
    assign pending_mask[r] = (cnt[r] != '0);
  end

  assign busy = |pending_mask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    src1_cnt = '0;
    src2_cnt = '0;
    dest_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (src1 == REG_FILE_ADDR_LEN'(r))       src1_cnt = cnt[r];
      if (src2 == REG_FILE_ADDR_LEN'(r))       src2_cnt = cnt[r];
      if (issue_dest == REG_FILE_ADDR_LEN'(r)) dest_cnt = cnt[r];
    end
  end

  always_comb begin
    lat_eff = issue_lat;
    if (issue_lat == '0)
      lat_eff = LAT_W'(1);
    else if (issue_lat > LAT_W'(MAX_LAT))
      lat_eff = LAT_W'(MAX_LAT);
  end

  // Without forwarding the consumer also waits out the MEM and WB stages.
  assign newcnt = CNT_W'(lat_eff - LAT_W'(1))
                + (forward_EN ? CNT_W'(0) : CNT_W'(NOFWD_EXTRA));

  assign raw = (src1_used && (src1_cnt != '0)) || (src2_used && (src2_cnt != '0));
  assign waw = issue_wb_en && (issue_dest != '0) && (dest_cnt > newcnt);

  assign stall        = issue_valid && (raw || waw);
  assign issue_accept = issue_valid && !stall;

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      raw_stalls   <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (stall && raw && (raw_stalls != '1))
        raw_stalls <= raw_stalls + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench: directed hazard scenarios plus random traffic vs a ready-time model.
// Define SCOREBOARD_STATS_EN to also check the statistics counters.
module tb_scoreboard_hazard_unit;

  localparam int NUM_REGS    = 16;
  localparam int MAX_LAT     = 8;
  localparam int NOFWD_EXTRA = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        forward_EN = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_wb_en = 1'b0;
  logic [3:0]  issue_dest = '0;
  logic [3:0]  issue_lat = '0;
  logic [3:0]  src1 = '0;
  logic        src1_used = 1'b0;
  logic [3:0]  src2 = '0;
  logic        src2_used = 1'b0;
  logic        stall, busy;
  logic [15:0] pending_mask;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles, raw_stalls;
`endif

  scoreboard_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .forward_EN   (forward_EN),
    .issue_valid  (issue_valid),
    .issue_wb_en  (issue_wb_en),
    .issue_dest   (issue_dest),
    .issue_lat    (issue_lat),
    .src1         (src1),
    .src1_used    (src1_used),
    .src2         (src2),
    .src2_used    (src2_used),
    .stall        (stall),
    .busy         (busy),
    .pending_mask (pending_mask)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles (stall_cycles)
    , .raw_stalls   (raw_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        busy;
    logic [15:0] mask;
    logic        raw;
    logic        accept;
    int          newcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: absolute cycle at which each register's result becomes available.
  int   ready [NUM_REGS];
  int   now = 0;
  int   m_stall_cycles = 0;
  int   m_raw_stalls = 0;
  logic last_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  function automatic int rem(input logic [3:0] r);
    return (ready[r] > now) ? ready[r] - now : 0;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    int   lat;
    logic waw;
    lat = int'(issue_lat);
    if (lat < 1) lat = 1;
    if (lat > MAX_LAT) lat = MAX_LAT;
    e.newcnt = lat - 1 + (forward_EN ? 0 : NOFWD_EXTRA);
    e.raw    = (src1_used && rem(src1) > 0) || (src2_used && rem(src2) > 0);
    waw      = issue_wb_en && issue_dest != 0 && rem(issue_dest) > e.newcnt;
    e.stall  = issue_valid && (e.raw || waw);
    e.accept = issue_valid && !e.stall;
    e.mask   = '0;
    for (int r = 1; r < NUM_REGS; r++) e.mask[r] = (rem(4'(r)) > 0);
    e.busy   = |e.mask;
    return e;
  endfunction

  // One clock cycle: predict, let the monitor compare, then advance the model.
  task automatic tick();
    exp_t e;
    e = model_eval();
    exp_q.push_back(e);
    @(negedge clk);
    last_stall = stall;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
      m_stall_cycles = 0;
      m_raw_stalls   = 0;
    end else begin
      if (e.stall) begin
        m_stall_cycles++;
        if (e.raw) m_raw_stalls++;
      end
      if (e.accept && issue_wb_en && issue_dest != 0)
        ready[issue_dest] = now + 1 + e.newcnt;
    end
    now++;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", 32'(stall), 32'(e.stall));
        check("busy", 32'(busy), 32'(e.busy));
        check("pending_mask", 32'(pending_mask), 32'(e.mask));
      end
    end
  end

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_wb_en = 1'b0; src1_used = 1'b0; src2_used = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue_op(input logic [3:0] dest, input logic [3:0] lat);
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = dest; issue_lat = lat;
    src1_used = 1'b0; src2_used = 1'b0;
    tick();
    idle_inputs();
  endtask

  // Hold an instruction in ID until it issues; count DUT stall cycles (bounded).
  task automatic consume(input string name, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2, input logic wb,
                         input logic [3:0] dest, input logic [3:0] lat, input int exp_stalls);
    int n = 0;
    issue_valid = 1'b1; issue_wb_en = wb; issue_dest = dest; issue_lat = lat;
    src1 = s1; src1_used = u1; src2 = s2; src2_used = u2;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!last_stall) break;
      n++;
    end
    idle_inputs();
    check(name, 32'(n), 32'(exp_stalls));
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
    tick();
    do_reset();
    check("reset_busy", 32'(busy), 32'd0);

    // Reset in the middle of a countdown discards it.
    forward_EN = 1'b1;
    issue_op(4'd6, 4'd4);
    check("pending_before_rst", 32'(pending_mask[6]), 32'd1);
    do_reset();
    check("rst_mask", 32'(pending_mask), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();

    // Forwarding: ALU->use free, load->use one bubble.
    do_reset();
    issue_op(4'd3, 4'd1);
    consume("alu_use_fwd", 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd1, 0);
    do_reset();
    issue_op(4'd5, 4'd2);
    consume("load_use_fwd", 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 4'd1, 1);
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles", stall_cycles, 32'd1);
    check("raw_stalls", raw_stalls, 32'd1);
`endif

    // No forwarding: ALU->use waits out MEM and WB.
    do_reset();
    forward_EN = 1'b0;
    issue_op(4'd3, 4'd1);
    consume("alu_use_nofwd", 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd1, 2);
    forward_EN = 1'b1;

    // WAW: short op to a register a long op still owns.
    do_reset();
    issue_op(4'd7, 4'd4);
    consume("waw_stall", 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 4'd1, 3);
    tick();
    check("waw_cleared", 32'(pending_mask[7]), 32'd0);

    // Register 0 is never tracked.
    do_reset();
    issue_op(4'd0, 4'd4);
    check("dest0_mask", 32'(pending_mask[0]), 32'd0);
    consume("dest0_use", 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd1, 0);

    // Random traffic, including clamped latencies, mode flips and stray resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      forward_EN  = ($urandom_range(0, 7) != 0);
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_wb_en = $urandom_range(0, 1);
      issue_dest  = 4'($urandom_range(0, 15));
      issue_lat   = 4'($urandom_range(0, 15));
      src1        = 4'($urandom_range(0, 15));
      src1_used   = $urandom_range(0, 1);
      src2        = 4'($urandom_range(0, 15));
      src2_used   = $urandom_range(0, 1);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 12; i++) tick();
    check("drained_busy", 32'(busy), 32'd0);
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles_final", stall_cycles, 32'(m_stall_cycles));
    check("raw_stalls_final", raw_stalls, 32'(m_raw_stalls));
`endif

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
